// File: rtl/uart_byte_tx_pkg.sv
// Shared framing definitions for the UART byte transmitter and the matching receive path.
// Both directions import this package so state encodings and frame width always agree.
package uart_byte_tx_pkg;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 69;
   localparam int BIT_IDX_W            = $clog2(DATA_BITS);

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t ST_IDLE  = 2'd0;
   localparam uart_state_t ST_START = 2'd1;
   localparam uart_state_t ST_DATA  = 2'd2;
   localparam uart_state_t ST_STOP  = 2'd3;

   // Line level to drive for the bit period the FSM is currently in.
   function automatic logic line_level(input uart_state_t state, input logic data_bit);
      logic level;
      level = 1'b1;
      case (state)
         ST_START: level = 1'b0;
         ST_DATA:  level = data_bit;
         default:  level = 1'b1;
      endcase
      return level;
   endfunction

endpackage : uart_byte_tx_pkg

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared by the transmit and receive paths; clear holds the count at zero.
module uart_baud_tick
   import uart_byte_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk_8mhz,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_8mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule : uart_baud_tick

// File: rtl/uart_byte_tx.sv
// Byte-level UART transmitter: valid/ready input, one-entry holding register, 8N1/8N2 framing.
// The holding register lets the next byte start immediately after the current stop bit.
module uart_byte_tx
   import uart_byte_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk_8mhz,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx_wire,
   output logic       busy,
   output logic       done
);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

   uart_state_t          state;
   uart_state_t          state_nxt;
   logic [DATA_BITS-1:0] shifter;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_full;
   logic [BIT_IDX_W-1:0] bit_idx;
   logic                 stop_idx;
   logic                 tick;
   logic                 accept;
   logic                 last_stop;
   logic                 frame_end;
   logic                 load;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_8mhz (clk_8mhz),
      .rst_n    (rst_n),
      .clear    (state == ST_IDLE),
      .tick     (tick)
   );

   assign in_ready  = ~hold_full;
   assign accept    = in_valid & in_ready;
   assign busy      = (state != ST_IDLE);
   assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
   assign frame_end = (state == ST_STOP) && tick && last_stop;

   // A load empties the holding register; in_ready is low then, so accept and load never coincide.
   assign load = hold_full && ((state == ST_IDLE) || frame_end);

   // NOTE: always_comb assigns a default first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (hold_full) state_nxt = ST_START;
         end
         ST_START: begin
            if (tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (tick && (bit_idx == LAST_BIT)) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (frame_end) state_nxt = hold_full ? ST_START : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_8mhz or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         hold_full <= 1'b0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         tx_wire   <= 1'b1;
         done      <= 1'b0;
      end else begin
         state <= state_nxt;

         if (load) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold_full <= 1'b1;
         end

         if (state != ST_DATA) begin
            bit_idx <= '0;
         end else if (tick) begin
            bit_idx <= bit_idx + 1'b1;
         end

         if (state != ST_STOP) begin
            stop_idx <= 1'b0;
         end else if (tick) begin
            stop_idx <= ~stop_idx;
         end

         // Pin follows the state one cycle later, straight from a flop.
         tx_wire <= line_level(state, shifter[0]);
         done    <= frame_end;
      end
   end

   // NOTE: pure data registers carry no reset; hold_full and state qualify them, so reset values never matter.
   always_ff @(posedge clk_8mhz) begin
      if (accept) begin
         hold_data <= in_data;
      end

      if (load) begin
         shifter <= hold_data;
      end else if ((state == ST_DATA) && tick) begin
         shifter <= shifter >> 1;
      end
   end

endmodule : uart_byte_tx

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: scoreboard of offered bytes against a line-decoding model.
// A second instance with two stop bits covers 8N2 framing.
`timescale 1ns/1ps
module tb_uart_byte_tx;

   localparam int CPB = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx1;
   logic       busy1;
   logic       done1;
   logic [7:0] in2_data;
   logic       in2_valid;
   logic       in2_ready;
   logic       tx2;
   logic       busy2;
   logic       done2;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   int         frame_starts[$];
   int         frame_count = 0;
   int         done_count  = 0;
   bit         mon_active  = 0;
   int         mon_k       = 0;
   logic [7:0] mon_byte;

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .clk_8mhz (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_wire  (tx1),
      .busy     (busy1),
      .done     (done1)
   );

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk_8mhz (clk),
      .rst_n    (rst_n),
      .in_data  (in2_data),
      .in_valid (in2_valid),
      .in_ready (in2_ready),
      .tx_wire  (tx2),
      .busy     (busy2),
      .done     (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line model for the 8N1 instance: samples mid-bit, checks framing, pops the scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_active = 0;
         mon_k      = 0;
      end else begin
         if (done1) done_count++;
         if (!mon_active) begin
            if (tx1 == 1'b0) begin
               mon_active = 1;
               mon_k      = 1;
               frame_count++;
               frame_starts.push_back(cyc);
            end
         end else begin
            mon_k++;
         end
         if (mon_active && (mon_k % CPB == 2)) begin
            int bi;
            bi = mon_k / CPB;
            if (bi == 0) begin
               n_checks++;
               if (tx1 !== 1'b0) $display("FAIL start_bit: got %b want 0", tx1);
               else n_pass++;
            end else if (bi <= 8) begin
               mon_byte[bi-1] = tx1;
            end else begin
               n_checks++;
               if (tx1 !== 1'b1) $display("FAIL stop_bit: got %b want 1", tx1);
               else n_pass++;
               n_checks++;
               if (exp_q.size() == 0) begin
                  $display("FAIL rx_byte: got %h with nothing expected", mon_byte);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (mon_byte !== e) $display("FAIL rx_byte: got %h want %h", mon_byte, e);
                  else n_pass++;
               end
            end
         end
         if (mon_active && mon_k == 10 * CPB) mon_active = 0;
      end
   end

   function automatic logic exp_level(input logic [7:0] b, input int k);
      int bi;
      bi = (k - 1) / CPB;
      if (bi == 0) return 1'b0;
      if (bi <= 8) return b[bi-1];
      return 1'b1;
   endfunction

   // Drives a byte and keeps in_valid high; returns the edge count at which it was accepted.
   task automatic offer(input logic [7:0] b, input int max_wait, output int acc_cyc);
      in_data  = b;
      in_valid = 1'b1;
      exp_q.push_back(b);
      acc_cyc  = -1;
      for (int i = 0; i < max_wait && acc_cyc < 0; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
         end else begin
            @(posedge clk); #1;
         end
      end
      n_checks++;
      if (acc_cyc < 0) begin
         $display("FAIL accept_%h: got no acceptance want accepted within %0d cycles", b, max_wait);
         in_valid = 1'b0;
      end else begin
         n_pass++;
      end
   endtask

   task automatic wait_drain(input string name, input int max_wait);
      bit drained;
      drained = 0;
      for (int i = 0; i < max_wait && !drained; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mon_active && !busy1) drained = 1;
      end
      n_checks++;
      if (!drained) $display("FAIL %s_drain: got %0d bytes pending want 0", name, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in2_valid = 1'b0; in2_data = '0;
      #12;
      n_checks++;
      if ({tx1, in_ready, busy1, done1} !== 4'b1100)
         $display("FAIL reset_outputs: got tx/rdy/busy/done=%b want 1100", {tx1, in_ready, busy1, done1});
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if ({tx1, in_ready, busy1, done1} !== 4'b1100) begin
            $display("FAIL idle_c%0d: got tx/rdy/busy/done=%b want 1100", i, {tx1, in_ready, busy1, done1});
            bad++;
         end else n_pass++;
      end
      n_checks++;
      if (done_count !== 0) $display("FAIL idle_done: got %0d pulses want 0", done_count);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int acc;
      int d0;
      d0 = done_count;
      offer(8'h55, 5, acc);
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx1 !== 1'b1) $display("FAIL latency_idle%0d: got %b want 1", i, tx1);
         else n_pass++;
      end
      for (int k = 1; k <= 10 * CPB; k++) begin
         @(negedge clk);
         n_checks++;
         if (tx1 !== exp_level(8'h55, k) || done1 !== (k == 10 * CPB))
            $display("FAIL frame55_k%0d: got tx=%b done=%b want tx=%b done=%b",
                     k, tx1, done1, exp_level(8'h55, k), (k == 10 * CPB));
         else n_pass++;
         if (k == 20) begin
            n_checks++;
            if (busy1 !== 1'b1) $display("FAIL busy_mid: got %b want 1", busy1);
            else n_pass++;
         end
      end
      @(negedge clk);
      n_checks++;
      if (busy1 !== 1'b0 || tx1 !== 1'b1 || done1 !== 1'b0)
         $display("FAIL after55: got busy=%b tx=%b done=%b want 0 1 0", busy1, tx1, done1);
      else n_pass++;
      wait_drain("single", 20);
      n_checks++;
      if (done_count - d0 !== 1) $display("FAIL done55_count: got %0d want 1", done_count - d0);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int acc1, acc2, f0, d0;
      f0 = frame_starts.size();
      d0 = done_count;
      offer(8'hA5, 5, acc1);
      offer(8'h3C, 10, acc2);
      in_valid = 1'b0;
      wait_drain("b2b", 200);
      n_checks++;
      if (frame_starts.size() - f0 !== 2) begin
         $display("FAIL b2b_frames: got %0d want 2", frame_starts.size() - f0);
      end else if (frame_starts[f0+1] - frame_starts[f0] !== 10 * CPB) begin
         $display("FAIL b2b_gap: got start spacing %0d want %0d",
                  frame_starts[f0+1] - frame_starts[f0], 10 * CPB);
      end else n_pass++;
      n_checks++;
      if (done_count - d0 !== 2) $display("FAIL b2b_done: got %0d want 2", done_count - d0);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_hold_off();
      int acc1, acc2, acc3;
      offer(8'h11, 5, acc1);
      offer(8'h22, 10, acc2);
      n_checks++;
      if (acc2 - acc1 !== 2) $display("FAIL hold_acc2: got +%0d want +2", acc2 - acc1);
      else n_pass++;
      in_data = 8'h0F;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL hold_ready: got %b want 0", in_ready);
      else n_pass++;
      @(posedge clk); #1;
      offer(8'h0F, 100, acc3);
      in_valid = 1'b0;
      n_checks++;
      if (acc3 - acc1 !== 10 * CPB + 2) $display("FAIL hold_acc3: got +%0d want +%0d", acc3 - acc1, 10 * CPB + 2);
      else n_pass++;
      wait_drain("hold", 250);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int acc1, acc2, fc;
      offer(8'hFF, 5, acc1);
      offer(8'h81, 10, acc2);
      in_valid = 1'b0;
      while (cyc < acc1 + 2 + 4 * CPB + 1) begin
         @(posedge clk); #1;
      end
      #2;
      n_checks++;
      if (busy1 !== 1'b1) $display("FAIL pre_reset_busy: got %b want 1", busy1);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tx1, busy1, in_ready, done1} !== 4'b1010)
         $display("FAIL mid_reset: got tx/busy/rdy/done=%b want 1010", {tx1, busy1, in_ready, done1});
      else n_pass++;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fc = frame_count;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         n_checks++;
         if (tx1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL post_reset_c%0d: got tx=%b busy=%b want 1 0", i, tx1, busy1);
         else n_pass++;
      end
      n_checks++;
      if (frame_count !== fc) $display("FAIL post_reset_frames: got %0d want %0d", frame_count, fc);
      else n_pass++;
      @(posedge clk); #1;
      offer(8'h5A, 5, acc1);
      in_valid = 1'b0;
      wait_drain("recover", 80);
      @(posedge clk); #1;
   endtask

   task automatic test_stop2();
      bit ok;
      int d;
      in2_data  = 8'h00;
      in2_valid = 1'b1;
      @(negedge clk);
      ok = in2_ready;
      @(posedge clk); #1;
      in2_valid = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL stop2_accept: got ready=0 want 1");
      else n_pass++;
      d = 0;
      for (int k = -1; k <= 11 * CPB; k++) begin
         logic e_tx;
         @(negedge clk);
         e_tx = (k >= 1 && k <= 9 * CPB) ? 1'b0 : 1'b1;
         if (done2) d++;
         n_checks++;
         if (tx2 !== e_tx || done2 !== (k == 11 * CPB))
            $display("FAIL stop2_k%0d: got tx=%b done=%b want tx=%b done=%b",
                     k, tx2, done2, e_tx, (k == 11 * CPB));
         else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (busy2 !== 1'b0 || d !== 1) $display("FAIL stop2_end: got busy=%b pulses=%0d want 0 1", busy2, d);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_off();
      test_reset_mid();
      test_stop2();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_uart_byte_tx
